// File: rtl/mul_rr_sequencer.sv
// mul_rr_sequencer: round-robin controller for a shared repeated-addition multiplier datapath.
// Optional macro MUL_ZERO_SKIP_EN jumps from LDB straight to DONE when either granted operand is zero.
module mul_rr_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         grant,
  output logic         lda,
  output logic         ldb,
  output logic         clrp,
  output logic         ldp,
  output logic         decb,
  output logic [W-1:0] bus_out,
  input  logic         eqz,
  input  logic [W-1:0] prod_in
);
  typedef enum logic [2:0] {IDLE, LDA, LDB, CHK, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, last_q, last_d, mask_q, mask_d;
  logic e0, e1, skip;
  logic [W-1:0] opa, opb;
  assign opa = grant_q ? a1 : a0;
  assign opb = grant_q ? b1 : b0;
`ifdef MUL_ZERO_SKIP_EN
  assign skip = (opa == '0) || (opb == '0);
`else
  assign skip = 1'b0;
`endif
  // mask_q marks the single IDLE cycle after DONE; last_q then holds the client just served
  assign e0 = req0 && !(mask_q && !last_q);
  assign e1 = req1 && !(mask_q && last_q);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    mask_d  = (state_q == DONE);
    case (state_q)
      IDLE: if (e0 || e1) begin
        grant_d = (e0 && e1) ? ~last_q : e1;
        state_d = LDA;
      end
      LDA:  state_d = LDB;
      LDB:  state_d = skip ? DONE : CHK;
      CHK:  state_d = eqz ? DONE : ADD;
      ADD:  state_d = CHK;
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      mask_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
    end
  end
  assign busy    = (state_q != IDLE);
  assign grant   = grant_q;
  assign lda     = (state_q == LDA);
  assign ldb     = (state_q == LDB);
  assign clrp    = (state_q == LDB);
  assign ldp     = (state_q == ADD);
  assign decb    = (state_q == ADD);
  assign bus_out = (state_q == LDA) ? opa : (state_q == LDB) ? opb : '0;
  assign ack0    = (state_q == DONE) && !grant_q;
  assign ack1    = (state_q == DONE) && grant_q;
  assign result  = (state_q == DONE) ? prod_in : '0;
endmodule

// File: tb/tb_mul_rr_sequencer.sv
// tb_mul_rr_sequencer: directed and random jobs against a simple datapath and a product/latency model.
module tb_mul_rr_sequencer;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic ack0, ack1, busy, grant, lda, ldb, clrp, ldp, decb, eqz;
  logic [W-1:0] result, bus_out, prod_in;
  logic [W-1:0] ra = '0, rb = '0, rp = '0;
  int checks = 0, errors = 0, both_ack = 0;

  mul_rr_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result(result), .busy(busy), .grant(grant), .lda(lda), .ldb(ldb),
    .clrp(clrp), .ldp(ldp), .decb(decb), .bus_out(bus_out), .eqz(eqz), .prod_in(prod_in)
  );

  always #5 clk = ~clk;

  // Datapath: A, B, P registers driven by the sequencer strobes
  always @(posedge clk) begin
    if (lda) ra <= bus_out;
    if (ldb) rb <= bus_out;
    else if (decb) rb <= rb - 16'd1;
    if (clrp) rp <= '0;
    else if (ldp) rp <= rp + ra;
  end
  assign eqz = (rb == '0);
  assign prod_in = rp;

  always @(negedge clk) if (ack0 && ack1) both_ack <= both_ack + 1;

  function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ZERO_SKIP_EN
    if (a == '0 || b == '0) return 3;
`endif
    return 4 + 2 * int'(b);
  endfunction

  function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, grant, lda, ldb, clrp, ldp, decb, ack0, ack1, bus_out, result});
  endfunction

  // Called on a negedge in IDLE; that cycle is cycle 0 of the job
  task automatic run_job(input bit c, input logic [W-1:0] a, input logic [W-1:0] b);
    int n, pulses, wrong, exp_lat;
    bit got;
    logic [W-1:0] res;
    logic g;
    exp_lat = lat(a, b);
    if (c) begin a1 = a; b1 = b; req1 = 1'b1; end
    else begin a0 = a; b0 = b; req0 = 1'b1; end
    n = 0; pulses = 0; wrong = 0; got = 0; res = '0; g = 1'b0;
    while (!got && n < exp_lat + 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ldp) pulses++;
      if (c ? ack0 : ack1) wrong++;
      if (c ? ack1 : ack0) begin got = 1; res = result; g = grant; end
    end
    chk("ack_seen", 64'(got), 64'd1);
    chk("latency", 64'(n), 64'(exp_lat));
    chk("result", 64'(res), 64'(prod(a, b)));
    chk("grant", 64'(g), 64'(c));
    chk("add_pulses", 64'(pulses), (exp_lat == 3) ? 64'd0 : 64'(b));
    chk("other_ack", 64'(wrong), 64'd0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int n, t0, t1, ta, tb, k;
    logic [W-1:0] r0, r1, ra_, rb_;
    logic g0, g1;
    bit c;
    logic gs [4];
    logic [W-1:0] rs [4];
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 64'(busy), 64'd0);
    run_job(0, 16'd17, 16'd5);
    run_job(0, 16'd300, 16'd300);
    run_job(0, 16'd9, 16'd0);
    run_job(0, 16'd0, 16'd5);
    run_job(1, 16'd11, 16'd3);
    // Simultaneous requests: client 0 first, client 1 in the IDLE after DONE
    a0 = 16'd3; b0 = 16'd4; a1 = 16'd7; b1 = 16'd2; req0 = 1'b1; req1 = 1'b1;
    n = 0; t0 = -1; t1 = -1; r0 = '0; r1 = '0; g0 = 1'b1; g1 = 1'b0;
    while ((t0 < 0 || t1 < 0) && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ack0) begin t0 = n; r0 = result; g0 = grant; req0 = 1'b0; end
      if (ack1) begin t1 = n; r1 = result; g1 = grant; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("dual_ack0_cycle", 64'(t0), 64'd12);
    chk("dual_result0", 64'(r0), 64'd12);
    chk("dual_grant0", 64'(g0), 64'd0);
    chk("dual_ack1_cycle", 64'(t1), 64'(12 + 1 + lat(16'd7, 16'd2)));
    chk("dual_result1", 64'(r1), 64'd14);
    chk("dual_grant1", 64'(g1), 64'd1);
    repeat (3) @(negedge clk);
    // Both clients held for four transactions: grants must alternate
    a0 = 16'd2; b0 = 16'd1; a1 = 16'd5; b1 = 16'd1; req0 = 1'b1; req1 = 1'b1;
    k = 0; n = 0;
    while (k < 4 && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ack0 || ack1) begin gs[k] = grant; rs[k] = result; k++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("fair_count", 64'(k), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("fair_grant", 64'(gs[i]), 64'(i % 2));
      chk("fair_result", 64'(rs[i]), (i % 2) ? 64'd5 : 64'd2);
    end
    repeat (3) @(negedge clk);
    // Single client held: post-ack mask inserts one extra IDLE cycle
    a0 = 16'd4; b0 = 16'd2; req0 = 1'b1;
    n = 0; ta = -1; tb = -1;
    while (tb < 0 && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ack0) begin if (ta < 0) ta = n; else tb = n; end
    end
    req0 = 1'b0;
    chk("mask_interval", 64'(tb - ta), 64'd10);
    repeat (3) @(negedge clk);
    // Async reset during ADD abandons the job; held request restarts it
    a0 = 16'd17; b0 = 16'd5; req0 = 1'b1;
    n = 0;
    while (!ldp && n < 50) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk("reached_add", 64'(ldp), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", outs(), 64'd0);
    @(negedge clk);
    chk("reset_held", outs(), 64'd0);
    rst_n = 1'b1;
    run_job(0, 16'd17, 16'd5);
    for (int i = 0; i < 8; i++) begin
      c = 1'($urandom_range(0, 1));
      ra_ = 16'($urandom);
      rb_ = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) ra_ = '0;
      run_job(c, ra_, rb_);
    end
    chk("acks_exclusive", 64'(both_ack), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_rr_sequencer.md
Name: mul_rr_sequencer

Overview:
- Controller and arbiter for the repeated-addition multiplier datapath.
- Two clients each present an operand pair (a, b). The block grants the datapath round-robin and sequences the register loads, clear, add and decrement steps.
- Completion is detected from the datapath zero flag. The product is returned to the granted client with a one-cycle ack.
- Sits between the client logic and the datapath; replaces the single-client controller when the multiplier is shared.

Parameters:
- W, 16, operand, bus and product width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  client 0 request, level.
- a0  in  W  client 0 multiplicand.
- b0  in  W  client 0 multiplier.
- req1  in  1  client 1 request, level.
- a1  in  W  client 1 multiplicand.
- b1  in  W  client 1 multiplier.
- ack0  out  1  client 0 done pulse.
- ack1  out  1  client 1 done pulse.
- result  out  W  product, valid while ack0/ack1 high.
- busy  out  1  high in every state except IDLE.
- grant  out  1  id of the served client (0/1).
- lda  out  1  datapath: load A from bus_out.
- ldb  out  1  datapath: load B from bus_out.
- clrp  out  1  datapath: clear P.
- ldp  out  1  datapath: P <= P + A.
- decb  out  1  datapath: B <= B - 1.
- bus_out  out  W  datapath data bus.
- eqz  in  1  datapath: B == 0, combinational from the B register.
- prod_in  in  W  datapath: P register value.

Behaviour:
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - All outputs are 0, including bus_out and result.
  - last_grant = 1, so client 0 wins the first tie.
  - Reset mid-operation abandons the operation: no ack is issued and the datapath contents are don't-care.
- All outputs are registered or decoded from state only. No combinational path from req to outputs.
- States:
  - IDLE: arbitration.
    - If exactly one eligible req is high, grant it.
    - If both are high, grant the client != last_grant.
    - On a grant, latch grant and go to LDA. Otherwise stay in IDLE.
  - LDA: bus_out = a of the granted client; lda = 1 -> LDB.
  - LDB: bus_out = b of the granted client; ldb = 1, clrp = 1 -> CHK.
  - CHK: all strobes 0.
    - eqz = 1 -> DONE.
    - eqz = 0 -> ADD.
  - ADD: ldp = 1, decb = 1 -> CHK.
  - DONE:
    - ack of the granted client = 1 and result = prod_in, for exactly one cycle.
    - last_grant <= grant -> IDLE.
- Latency: with the request sampled in IDLE at cycle 0, ack is high in cycle 4 + 2*b.
- Operands are read from the client inputs in LDA and LDB. The client must hold a/b stable from req rise until ack.
- A req dropped mid-operation is ignored: the operation completes and ack still pulses.
- Post-ack mask: in the IDLE cycle directly after DONE, the just-served client's req is not eligible. This prevents re-grant before the client deasserts.
- Fairness: under continuous requests from both clients, grants alternate 0, 1, 0, 1.
- Arithmetic:
  - The product is modulo 2^W, truncated by the datapath adder.
  - b = 0 gives 0 iterations and result 0.
  - a = 0 gives b iterations and result 0.
- ack0 and ack1 are never high together. grant is stable from LDA through DONE.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined:
  - In LDB, if a == 0 or b == 0 (granted operands), clrp and ldb assert as normal but the next state is DONE, skipping CHK.
  - Ack comes at cycle 3 and result = 0 (P just cleared).
- Undefined: no skip; timing follows the general formula.

Test Plan:
- Single client, reset released, req0 with a0=17, b0=5 -> ack0 at cycle 14, result=85; exactly 5 ldp/decb pulses; ack1 stays 0.
- req0 (a=3, b=4) and req1 (a=7, b=2) both rising in the same cycle after reset:
  - client 0 first: ack0 at cycle 12, result=12;
  - client 1 granted in the following IDLE: result=14;
  - grant sequence is 0, 1.
- Both clients held requesting for 4 transactions -> grants 0, 1, 0, 1. The post-ack mask prevents a back-to-back re-grant of the same client.
- Overflow: a0=300, b0=300 -> result=24464 (90000 mod 65536), ack0 at cycle 604.
- b0=0, a0=9 -> ack0 at cycle 4, result=0. Zero-skip with a0=0, b0=5: ack0 at cycle 3 with MUL_ZERO_SKIP_EN defined, at cycle 14 without.
- rst_n pulsed low during ADD of a 17x5 job -> all outputs 0 immediately, no ack. With req0 still high after release, the job restarts at LDA and completes with result=85.
